// File: rtl/fb_rect_fill_scheduler_if.sv
// Bundle between drawing clients, the fill scheduler and the framebuffer write port.
// The scheduler takes the slave view; clients and framebuffer together form the master.
interface fb_rect_fill_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*X_W-1:0]     req_x0;
  logic [NUM_REQ*Y_W-1:0]     req_y0;
  logic [NUM_REQ*X_W-1:0]     req_x1;
  logic [NUM_REQ*Y_W-1:0]     req_y1;
  logic [NUM_REQ*COLOR_W-1:0] req_color;
  logic [NUM_REQ-1:0]         gnt;
  logic                       done;
  logic [2:0]                 done_id;
  logic                       busy;
  logic                       fb_we;
  logic [X_W-1:0]             fb_x;
  logic [Y_W-1:0]             fb_y;
  logic [COLOR_W-1:0]         fb_color;
  logic                       fb_ready;

  modport slave (
    input  req, req_x0, req_y0, req_x1, req_y1, req_color, fb_ready,
    output gnt, done, done_id, busy, fb_we, fb_x, fb_y, fb_color
  );

  modport master (
    output req, req_x0, req_y0, req_x1, req_y1, req_color, fb_ready,
    input  gnt, done, done_id, busy, fb_we, fb_x, fb_y, fb_color
  );
endinterface

// File: rtl/fb_rect_fill_scheduler.sv
// Round-robin arbiter that streams one granted solid rectangle at a time,
// in raster order, onto the shared framebuffer write port.
module fb_rect_fill_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3,
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 239
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  fb_rect_fill_scheduler_if.slave bus
);

  // state   | meaning
  // IDLE    | arbitrate pending requests
  // FILL    | stream pixels of the latched rectangle
  // DONE    | pulse done for the finished client
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         rr_q, rr_d;
  logic [2:0]         id_q, id_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [X_W-1:0]     x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [Y_W-1:0]     y1_q, y1_d, y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic [7:0]         req_pad;
  logic [3:0]         cand;
  logic               pick_valid;
  logic [2:0]         pick_idx;
  logic [X_W-1:0]     sel_x0, sel_x1, x1c;
  logic [Y_W-1:0]     sel_y0, sel_y1, y1c;
  logic [COLOR_W-1:0] sel_color;
  logic               rect_empty;
  logic               done_w;

  assign req_pad = 8'(bus.req);

  // First requester at or after the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!pick_valid && req_pad[cand[2:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    sel_x0    = '0;
    sel_y0    = '0;
    sel_x1    = '0;
    sel_y1    = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        sel_x0    = bus.req_x0[i*X_W +: X_W];
        sel_y0    = bus.req_y0[i*Y_W +: Y_W];
        sel_x1    = bus.req_x1[i*X_W +: X_W];
        sel_y1    = bus.req_y1[i*Y_W +: Y_W];
        sel_color = bus.req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Clipping keeps the == end-of-row/column compares from ever wrapping.
  assign x1c        = (sel_x1 > X_W'(X_MAX)) ? X_W'(X_MAX) : sel_x1;
  assign y1c        = (sel_y1 > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : sel_y1;
  assign rect_empty = (sel_x0 > x1c) || (sel_y0 > y1c);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    gnt_d   = '0;
    x0_d    = x0_q;
    x1_d    = x1_q;
    x_d     = x_q;
    y1_d    = y1_q;
    y_d     = y_q;
    color_d = color_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          id_d    = pick_idx;
          rr_d    = (pick_idx == 3'(NUM_REQ-1)) ? 3'd0 : pick_idx + 3'd1;
          x0_d    = sel_x0;
          x_d     = sel_x0;
          x1_d    = x1c;
          y_d     = sel_y0;
          y1_d    = y1c;
          color_d = sel_color;
          state_d = rect_empty ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.fb_ready) begin
          if (x_q == x1_q) begin
            x_d = x0_q;
            if (y_q == y1_q) state_d = ST_DONE;
            else             y_d     = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      ST_DONE: begin
        // An empty rectangle enters DONE in its grant cycle; wait one cycle so done trails gnt.
        if (!(|gnt_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      x_q     <= '0;
      y1_q    <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x_q     <= x_d;
      y1_q    <= y1_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign done_w       = (state_q == ST_DONE) && !(|gnt_q);
  assign bus.done     = done_w;
  assign bus.done_id  = done_w ? id_q : 3'd0;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.fb_we    = (state_q == ST_FILL);
  assign bus.fb_x     = x_q;
  assign bus.fb_y     = y_q;
  assign bus.fb_color = color_q;

endmodule
